// File: rtl/multi_ch_byte_packer.sv
// Multi-channel FIFO snapshot to UART byte-frame packer.
// Frame: [sync] data bytes of enabled channels [checksum].
module multi_ch_byte_packer #(
  parameter int         NUM_CH    = 4,
  parameter int         WORD_W    = 16,
  parameter int         SYNC_EN   = 1,
  parameter logic [7:0] SYNC_BYTE = 8'hA5,
  parameter int         CSUM_EN   = 1
) (
  input  logic                     clk40M,
  input  logic                     nRst,
  input  logic [NUM_CH-1:0]        empty,
  output logic [NUM_CH-1:0]        rd,
  input  logic [NUM_CH*WORD_W-1:0] fifoOut,
  input  logic [NUM_CH-1:0]        chMask,
  input  logic                     msbFirst,
  output logic [7:0]               txData,
  output logic                     txValid,
  input  logic                     txReady,
  output logic                     busy,
  output logic                     frameDone,
  output logic [15:0]              frameCount
);

  localparam int BPW  = WORD_W / 8;
  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int BY_W = (BPW > 1) ? $clog2(BPW) : 1;

  typedef enum logic [2:0] {
    IDLE, LATCH, SYNC, DATA, SUM, DONE
  } state_t;

  state_t state, state_n;

  logic [NUM_CH-1:0]        mask_q;
  logic                     msb_q;
  logic [NUM_CH*WORD_W-1:0] snap;
  logic [CH_W-1:0]          ch_q;
  logic [CH_W-1:0]          first_ch;
  logic [CH_W-1:0]          next_ch;
  logic                     has_next;
  logic [BY_W-1:0]          byte_q;
  logic [BY_W-1:0]          byte_sel;
  logic [7:0]               csum;
  logic [WORD_W-1:0]        cur_word;
  logic                     start;
  logic                     xfer;
  logic                     last_byte;

  assign start     = (chMask != '0) &&
                     ((~empty & chMask) == chMask);
  assign xfer      = txValid && txReady;
  assign last_byte = (byte_q == BY_W'(BPW - 1));
  assign byte_sel  = msb_q ? (BY_W'(BPW - 1) - byte_q)
                           : byte_q;
  assign cur_word  = snap[int'(ch_q)*WORD_W +: WORD_W];
  assign busy      = (state != IDLE);
  assign frameDone = (state == DONE);

  // Lowest enabled channel, and next enabled one above ch_q
  always_comb begin
    first_ch = '0;
    next_ch  = ch_q;
    has_next = 1'b0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (mask_q[i]) begin
        first_ch = CH_W'(i);
      end
      if (mask_q[i] && (i > int'(ch_q))) begin
        next_ch  = CH_W'(i);
        has_next = 1'b1;
      end
    end
  end

  // Next state, FIFO read strobe and byte presentation
  always_comb begin
    state_n = state;
    rd      = '0;
    txValid = 1'b0;
    txData  = '0;
    unique case (state)
      IDLE: begin
        if (start) begin
          state_n = LATCH;
          rd      = chMask & {NUM_CH{nRst}};
        end
      end
      LATCH: begin
        state_n = (SYNC_EN != 0) ? SYNC : DATA;
      end
      SYNC: begin
        txValid = 1'b1;
        txData  = SYNC_BYTE;
        if (xfer) state_n = DATA;
      end
      DATA: begin
        txValid = 1'b1;
        txData  = cur_word[int'(byte_sel)*8 +: 8];
        if (xfer && last_byte && !has_next) begin
          state_n = (CSUM_EN != 0) ? SUM : DONE;
        end
      end
      SUM: begin
        txValid = 1'b1;
        txData  = csum;
        if (xfer) state_n = DONE;
      end
      DONE: begin
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk40M) begin
    if (!nRst) state <= IDLE;
    else       state <= state_n;
  end

  // Frame registers, snapshot, byte walker, checksum, counter
  always_ff @(posedge clk40M) begin
    if (!nRst) begin
      mask_q     <= '0;
      msb_q      <= 1'b0;
      snap       <= '0;
      ch_q       <= '0;
      byte_q     <= '0;
      csum       <= '0;
      frameCount <= '0;
    end else begin
      if (state == IDLE && start) begin
        mask_q <= chMask;
        msb_q  <= msbFirst;
        csum   <= '0;
      end
      if (state == LATCH) begin
        for (int c = 0; c < NUM_CH; c++) begin
          if (mask_q[c]) begin
            snap[c*WORD_W +: WORD_W] <=
              fifoOut[c*WORD_W +: WORD_W];
          end
        end
        ch_q   <= first_ch;
        byte_q <= '0;
      end
      if (state == DATA && xfer) begin
        csum <= csum + txData;
        if (last_byte) begin
          byte_q <= '0;
          ch_q   <= next_ch;
        end else begin
          byte_q <= byte_q + 1'b1;
        end
      end
      if (state == DONE) begin
        frameCount <= frameCount + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_multi_ch_byte_packer.sv
// Directed bench for multi_ch_byte_packer.
// Default instance plus a 2ch/32b no-sync/no-sum instance.
module tb_multi_ch_byte_packer;

  logic        clk40M;
  logic        nRst;
  logic [3:0]  empty;
  logic [3:0]  rd;
  logic [63:0] fifoOut;
  logic [3:0]  chMask;
  logic        msbFirst;
  logic [7:0]  txData;
  logic        txValid;
  logic        txReady;
  logic        busy;
  logic        frameDone;
  logic [15:0] frameCount;

  logic [1:0]  empty2;
  logic [1:0]  rd2;
  logic [63:0] fifoOut2;
  logic [1:0]  chMask2;
  logic        msbFirst2;
  logic [7:0]  txData2;
  logic        txValid2;
  logic        txReady2;
  logic        busy2;
  logic        frameDone2;
  logic [15:0] frameCount2;

  int errs   = 0;
  int checks = 0;

  logic [7:0] got_q[$];
  int         rd_cnt;
  logic [3:0] rd_val;
  int         done_cnt;
  int         stable_err;
  logic       timeout;

  multi_ch_byte_packer dut (
    .clk40M(clk40M), .nRst(nRst),
    .empty(empty), .rd(rd), .fifoOut(fifoOut),
    .chMask(chMask), .msbFirst(msbFirst),
    .txData(txData), .txValid(txValid),
    .txReady(txReady), .busy(busy),
    .frameDone(frameDone), .frameCount(frameCount)
  );

  multi_ch_byte_packer #(
    .NUM_CH(2), .WORD_W(32),
    .SYNC_EN(0), .SYNC_BYTE(8'hA5), .CSUM_EN(0)
  ) dut2 (
    .clk40M(clk40M), .nRst(nRst),
    .empty(empty2), .rd(rd2), .fifoOut(fifoOut2),
    .chMask(chMask2), .msbFirst(msbFirst2),
    .txData(txData2), .txValid(txValid2),
    .txReady(txReady2), .busy(busy2),
    .frameDone(frameDone2), .frameCount(frameCount2)
  );

  initial clk40M = 1'b0;
  always #5 clk40M = ~clk40M;

  // Run one frame; empty goes high once rd is seen.
  // stall>0 holds txReady low for stall cycles per byte.
  task automatic collect(input int stall, input int maxc);
    logic [7:0] held;
    logic       holding;
    int         wait_c;
    logic       kill;
    held = '0; holding = 1'b0; wait_c = 0; kill = 1'b0;
    got_q.delete();
    rd_cnt = 0; rd_val = '0; done_cnt = 0;
    stable_err = 0; timeout = 1'b1;
    txReady = (stall == 0);
    for (int c = 0; c < maxc; c++) begin
      @(negedge clk40M);
      if (rd != '0) begin
        rd_cnt++;
        rd_val = rd;
        kill = 1'b1;
      end
      if (txValid && txReady) begin
        got_q.push_back(txData);
        holding = 1'b0;
      end else if (txValid) begin
        if (holding && txData !== held) stable_err++;
        held = txData;
        holding = 1'b1;
      end
      if (frameDone) begin
        done_cnt++;
        timeout = 1'b0;
      end
      @(posedge clk40M); #1;
      if (kill) empty = '1;
      if (stall > 0) begin
        if (txValid && !txReady) begin
          wait_c++;
          if (wait_c >= stall) txReady = 1'b1;
        end else if (txReady) begin
          txReady = 1'b0;
          wait_c = 0;
        end
      end
      if (!timeout) break;
    end
    txReady = 1'b1;
    checks++;
    if (timeout) begin
      errs++;
      $display("FAIL collect_timeout no frameDone in %0d cycles",
               maxc);
    end
  endtask

  task automatic test_reset();
    nRst = 1'b0;
    empty = '0;
    chMask = 4'hF;
    repeat (3) @(posedge clk40M);
    @(negedge clk40M);
    checks++;
    if ({rd, txValid, txData, busy, frameDone} !== 15'd0) begin
      errs++;
      $display("FAIL reset_outputs got rd=%h v=%b d=%h b=%b fd=%b want 0",
               rd, txValid, txData, busy, frameDone);
    end
    checks++;
    if (frameCount !== 16'd0) begin
      errs++;
      $display("FAIL reset_count got %h want 0000", frameCount);
    end
    empty = '1;
    @(posedge clk40M); #1;
    nRst = 1'b1;
    @(posedge clk40M); #1;
  endtask

  task automatic test_mask_zero();
    int viol;
    viol = 0;
    chMask = 4'h0;
    empty = '0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk40M);
      if (rd != '0 || busy || txValid) viol++;
    end
    checks++;
    if (viol !== 0) begin
      errs++;
      $display("FAIL mask_zero got %0d active cycles want 0", viol);
    end
    @(posedge clk40M); #1;
    empty = '1;
    chMask = 4'hF;
  endtask

  task automatic test_lsb_first();
    logic [7:0] exp[10];
    exp = '{8'hA5, 8'h34, 8'h12, 8'h78, 8'h56,
            8'hBC, 8'h9A, 8'hF0, 8'hDE, 8'h38};
    chMask = 4'hF; msbFirst = 1'b0; empty = '0;
    collect(0, 100);
    checks++;
    if (got_q.size() !== 10) begin
      errs++;
      $display("FAIL lsb_len got %0d want 10", got_q.size());
    end
    for (int i = 0; i < 10; i++) begin
      checks++;
      if (got_q[i] !== exp[i]) begin
        errs++;
        $display("FAIL lsb_byte%0d got %h want %h", i, got_q[i], exp[i]);
      end
    end
    checks++;
    if (rd_cnt !== 1 || rd_val !== 4'hF) begin
      errs++;
      $display("FAIL lsb_rd got cnt=%0d rd=%h want 1/F", rd_cnt, rd_val);
    end
    checks++;
    if (done_cnt !== 1 || frameCount !== 16'd1) begin
      errs++;
      $display("FAIL lsb_done got pulses=%0d count=%0d want 1/1",
               done_cnt, frameCount);
    end
  endtask

  task automatic test_msb_first();
    logic [7:0] exp[10];
    exp = '{8'hA5, 8'h12, 8'h34, 8'h56, 8'h78,
            8'h9A, 8'hBC, 8'hDE, 8'hF0, 8'h38};
    chMask = 4'hF; msbFirst = 1'b1; empty = '0;
    collect(0, 100);
    msbFirst = 1'b0;
    checks++;
    if (got_q.size() !== 10) begin
      errs++;
      $display("FAIL msb_len got %0d want 10", got_q.size());
    end
    for (int i = 0; i < 10; i++) begin
      checks++;
      if (got_q[i] !== exp[i]) begin
        errs++;
        $display("FAIL msb_byte%0d got %h want %h", i, got_q[i], exp[i]);
      end
    end
    checks++;
    if (frameCount !== 16'd2) begin
      errs++;
      $display("FAIL msb_count got %0d want 2", frameCount);
    end
  endtask

  task automatic test_mask5();
    logic [7:0] exp[6];
    exp = '{8'hA5, 8'h34, 8'h12, 8'hBC, 8'h9A, 8'h9C};
    chMask = 4'b0101; empty = 4'b1010;
    collect(0, 100);
    chMask = 4'hF;
    checks++;
    if (got_q.size() !== 6) begin
      errs++;
      $display("FAIL mask5_len got %0d want 6", got_q.size());
    end
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (got_q[i] !== exp[i]) begin
        errs++;
        $display("FAIL mask5_byte%0d got %h want %h", i, got_q[i], exp[i]);
      end
    end
    checks++;
    if (rd_cnt !== 1 || rd_val !== 4'b0101) begin
      errs++;
      $display("FAIL mask5_rd got cnt=%0d rd=%h want 1/5", rd_cnt, rd_val);
    end
  endtask

  task automatic test_empty_hold();
    int viol;
    viol = 0;
    chMask = 4'hF; empty = 4'b0100;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk40M);
      if (rd != '0 || txValid || busy) viol++;
    end
    checks++;
    if (viol !== 0) begin
      errs++;
      $display("FAIL hold_idle got %0d active cycles want 0", viol);
    end
    @(posedge clk40M); #1;
    empty = 4'b0000;
    @(negedge clk40M);
    checks++;
    if (rd !== 4'hF) begin
      errs++;
      $display("FAIL hold_start_rd got %h want F", rd);
    end
    @(posedge clk40M); #1;
    empty = '1;
    @(negedge clk40M);
    checks++;
    if (txValid !== 1'b0 || busy !== 1'b1) begin
      errs++;
      $display("FAIL hold_latch got v=%b b=%b want 0/1", txValid, busy);
    end
    @(negedge clk40M);
    checks++;
    if (txValid !== 1'b1 || txData !== 8'hA5) begin
      errs++;
      $display("FAIL hold_first got v=%b d=%h want 1/A5", txValid, txData);
    end
    collect(0, 100);
    checks++;
    if (got_q.size() !== 9 || got_q[8] !== 8'h38 || rd_cnt !== 0) begin
      errs++;
      $display("FAIL hold_rest got n=%0d last=%h rd=%0d want 9/38/0",
               got_q.size(), got_q[8], rd_cnt);
    end
  endtask

  task automatic test_backpressure();
    logic [7:0] exp[10];
    exp = '{8'hA5, 8'h34, 8'h12, 8'h78, 8'h56,
            8'hBC, 8'h9A, 8'hF0, 8'hDE, 8'h38};
    chMask = 4'hF; msbFirst = 1'b0; empty = '0;
    collect(7, 400);
    checks++;
    if (got_q.size() !== 10) begin
      errs++;
      $display("FAIL bp_len got %0d want 10", got_q.size());
    end
    for (int i = 0; i < 10; i++) begin
      checks++;
      if (got_q[i] !== exp[i]) begin
        errs++;
        $display("FAIL bp_byte%0d got %h want %h", i, got_q[i], exp[i]);
      end
    end
    checks++;
    if (stable_err !== 0) begin
      errs++;
      $display("FAIL bp_stable got %0d changes want 0", stable_err);
    end
    checks++;
    if (frameCount !== 16'd5) begin
      errs++;
      $display("FAIL bp_count got %0d want 5", frameCount);
    end
  endtask

  task automatic test_reset_mid();
    int   n;
    logic hit;
    n = 0; hit = 1'b0;
    chMask = 4'hF; msbFirst = 1'b0; txReady = 1'b1; empty = '0;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk40M);
      if (n == 4 && txValid) begin
        hit = 1'b1;
        nRst = 1'b0;
        txReady = 1'b0;
        break;
      end
      if (txValid && txReady) n++;
      @(posedge clk40M); #1;
      if (busy) empty = '1;
    end
    checks++;
    if (!hit || txData !== 8'h56) begin
      errs++;
      $display("FAIL rmid_reach got hit=%b d=%h want 1/56", hit, txData);
    end
    empty = '1;
    @(posedge clk40M); #1;
    checks++;
    if ({rd, txValid, txData, busy, frameDone} !== 15'd0) begin
      errs++;
      $display("FAIL rmid_outputs got v=%b d=%h b=%b want 0",
               txValid, txData, busy);
    end
    checks++;
    if (frameCount !== 16'd0) begin
      errs++;
      $display("FAIL rmid_count got %0d want 0", frameCount);
    end
    @(posedge clk40M); #1;
    nRst = 1'b1;
    @(negedge clk40M);
    checks++;
    if (txValid !== 1'b0 || busy !== 1'b0) begin
      errs++;
      $display("FAIL rmid_idle got v=%b b=%b want 0/0", txValid, busy);
    end
    @(posedge clk40M); #1;
    empty = '0;
    collect(0, 100);
    checks++;
    if (got_q.size() !== 10 || got_q[0] !== 8'hA5 ||
        got_q[9] !== 8'h38) begin
      errs++;
      $display("FAIL rmid_next got n=%0d first=%h last=%h want 10/A5/38",
               got_q.size(), got_q[0], got_q[9]);
    end
    checks++;
    if (frameCount !== 16'd1) begin
      errs++;
      $display("FAIL rmid_next_count got %0d want 1", frameCount);
    end
  endtask

  task automatic test_wide();
    logic [7:0] exp[8];
    logic [7:0] q[$];
    logic [1:0] rdv;
    logic       kill;
    logic       done;
    exp = '{8'h44, 8'h33, 8'h22, 8'h11,
            8'hDD, 8'hCC, 8'hBB, 8'hAA};
    rdv = '0; kill = 1'b0; done = 1'b0;
    chMask2 = 2'b11; msbFirst2 = 1'b0; txReady2 = 1'b1;
    empty2 = 2'b00;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk40M);
      if (rd2 != '0) begin
        rdv = rd2;
        kill = 1'b1;
      end
      if (txValid2 && txReady2) q.push_back(txData2);
      if (frameDone2) done = 1'b1;
      @(posedge clk40M); #1;
      if (kill) empty2 = '1;
      if (done) break;
    end
    checks++;
    if (!done) begin
      errs++;
      $display("FAIL wide_timeout no frameDone want pulse");
    end
    checks++;
    if (q.size() !== 8) begin
      errs++;
      $display("FAIL wide_len got %0d want 8", q.size());
    end
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (q[i] !== exp[i]) begin
        errs++;
        $display("FAIL wide_byte%0d got %h want %h", i, q[i], exp[i]);
      end
    end
    checks++;
    if (rdv !== 2'b11 || frameCount2 !== 16'd1) begin
      errs++;
      $display("FAIL wide_rd_count got rd=%b cnt=%0d want 11/1",
               rdv, frameCount2);
    end
  endtask

  initial begin
    nRst = 1'b0;
    empty = '1; chMask = 4'hF; msbFirst = 1'b0; txReady = 1'b1;
    fifoOut = {16'hDEF0, 16'h9ABC, 16'h5678, 16'h1234};
    empty2 = '1; chMask2 = 2'b11; msbFirst2 = 1'b0; txReady2 = 1'b1;
    fifoOut2 = {32'hAABBCCDD, 32'h11223344};
    test_reset();
    test_mask_zero();
    test_lsb_first();
    test_msb_first();
    test_mask5();
    test_empty_hold();
    test_backpressure();
    test_reset_mid();
    test_wide();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
